// File: rtl/game_timer_keeper.sv
// Round supervisor for breakout: countdown timer kept in binary and BCD, lives,
// bonus time, pause/respawn handling and win/lose/game-over status.
module game_timer_keeper #(
  parameter int DIGITS        = 3,
  parameter int START_EASY    = 300,
  parameter int START_HARD    = 180,
  parameter int MAX_TIME      = 999,
  parameter int BONUS         = 5,
  parameter int LIVES         = 3,
  parameter int RESPAWN_TICKS = 2,
  parameter int WARN_TIME     = 10
) (
  input  logic                             tclk,
  input  logic                             reset,
  input  logic                             tick,
  input  logic                             start,
  input  logic                             pause,
  input  logic                             diff,
  input  logic                             brick_hit,
  input  logic                             ball_lost,
  input  logic                             level_clr,
  output logic [$clog2(MAX_TIME+1)-1:0]    time_bin,
  output logic [4*DIGITS-1:0]              bcd_time,
  output logic [2:0]                       lives,
  output logic [2:0]                       state,
  output logic                             running,
  output logic                             warn,
  output logic                             game_over,
  output logic                             win
);

  localparam int TW = $clog2(MAX_TIME + 1);
  localparam int BW = 4 * DIGITS;
  localparam int CW = (RESPAWN_TICKS > 0) ? $clog2(RESPAWN_TICKS + 1) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    LOST  = 3'd3,
    OVER  = 3'd4,
    WON   = 3'd5
  } state_t;

  // Double-dabble; digits are rotated through acc[3:0] to avoid variable slicing.
  function automatic logic [BW-1:0] to_bcd(input logic [TW-1:0] b);
    logic [BW-1:0] acc;
    logic [TW-1:0] sh;
    logic [3:0]    dig;
    acc = '0;
    sh  = b;
    for (int unsigned i = 0; i < TW; i++) begin
      for (int unsigned d = 0; d < DIGITS; d++) begin
        dig = acc[3:0];
        if (dig >= 4'd5) dig = dig + 4'd3;
        acc = (acc >> 4) | (BW'(dig) << (BW - 4));
      end
      acc = {acc[BW-2:0], sh[TW-1]};
      sh  = sh << 1;
    end
    return acc;
  endfunction

  function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] v);
    logic [BW-1:0] acc;
    logic [3:0]    dig;
    logic          borrow;
    acc    = v;
    borrow = 1'b1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      dig = acc[3:0];
      if (borrow) begin
        if (dig == 4'd0) begin
          dig = 4'd9;
        end else begin
          dig    = dig - 4'd1;
          borrow = 1'b0;
        end
      end
      acc = (acc >> 4) | (BW'(dig) << (BW - 4));
    end
    return acc;
  endfunction

  localparam logic [TW-1:0] EASY_T = TW'(START_EASY);
  localparam logic [TW-1:0] HARD_T = TW'(START_HARD);
  localparam logic [BW-1:0] EASY_B = to_bcd(EASY_T);
  localparam logic [BW-1:0] HARD_B = to_bcd(HARD_T);

  state_t          state_q, state_d;
  logic [TW-1:0]   time_d;
  logic [BW-1:0]   bcd_d;
  logic [2:0]      lives_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     sum;

  always_comb begin
    state_d = state_q;
    time_d  = time_bin;
    bcd_d   = bcd_time;
    lives_d = lives;
    cnt_d   = cnt_q;
    sum     = '0;
    if (!start || state_q == IDLE) begin
      // Forced IDLE already shows the reload values on the following cycle.
      time_d  = diff ? HARD_T : EASY_T;
      bcd_d   = diff ? HARD_B : EASY_B;
      lives_d = 3'(LIVES);
      cnt_d   = '0;
      state_d = start ? RUN : IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (level_clr) begin
            state_d = WON;
          end else if (ball_lost) begin
            lives_d = lives - 3'd1;
            cnt_d   = '0;
            state_d = (lives == 3'd1) ? OVER : LOST;
          end else if ((tick && time_bin == TW'(1)) || time_bin == '0) begin
            time_d  = '0;
            bcd_d   = '0;
            state_d = OVER;
          end else if (pause) begin
            state_d = PAUSE;
          end else begin
            sum = 32'(time_bin) + (brick_hit ? 32'(BONUS) : 32'd0) - (tick ? 32'd1 : 32'd0);
            if (sum > 32'(MAX_TIME)) sum = 32'(MAX_TIME);
            time_d = TW'(sum);
            if (brick_hit)
              bcd_d = to_bcd(TW'(sum));
            else if (tick)
              bcd_d = bcd_dec(bcd_time);
          end
        end
        PAUSE: begin
          if (!pause) state_d = RUN;
        end
        LOST: begin
          if (RESPAWN_TICKS == 0) begin
            state_d = RUN;
          end else if (tick) begin
            if (cnt_q == CW'(RESPAWN_TICKS - 1)) begin
              cnt_d   = '0;
              state_d = RUN;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge tclk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      time_bin  <= EASY_T;
      bcd_time  <= EASY_B;
      lives     <= 3'(LIVES);
      cnt_q     <= '0;
      running   <= 1'b0;
      warn      <= 1'b0;
      game_over <= 1'b0;
      win       <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_bin  <= time_d;
      bcd_time  <= bcd_d;
      lives     <= lives_d;
      cnt_q     <= cnt_d;
      running   <= (state_d == RUN);
      warn      <= (state_d == RUN) && (32'(time_d) <= 32'(WARN_TIME));
      game_over <= (state_d == OVER);
      win       <= (state_d == WON);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_game_timer_keeper.sv
// Directed bench for game_timer_keeper: expected results are queued as each
// step is driven and compared once the DUT has clocked that step.
module tb_game_timer_keeper;

  logic        tclk, reset, tick, start, pause, diff, brick_hit, ball_lost, level_clr;
  logic [9:0]  time_bin;
  logic [11:0] bcd_time;
  logic [2:0]  lives, state;
  logic        running, warn, game_over, win;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int    t;
    int    st;
    int    lv;
    string tag;
  } exp_t;
  exp_t sb[$];

  game_timer_keeper #(
    .DIGITS(3), .START_EASY(300), .START_HARD(180), .MAX_TIME(999),
    .BONUS(5), .LIVES(3), .RESPAWN_TICKS(2), .WARN_TIME(10)
  ) dut (
    .tclk(tclk), .reset(reset), .tick(tick), .start(start), .pause(pause),
    .diff(diff), .brick_hit(brick_hit), .ball_lost(ball_lost), .level_clr(level_clr),
    .time_bin(time_bin), .bcd_time(bcd_time), .lives(lives), .state(state),
    .running(running), .warn(warn), .game_over(game_over), .win(win)
  );

  initial tclk = 1'b0;
  always #5 tclk = ~tclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] exp_bcd(input int t);
    return 12'(((t / 100) % 10) * 256 + ((t / 10) % 10) * 16 + (t % 10));
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input int t, input int st, input int lv, input string tag);
    exp_t e;
    e.t = t; e.st = st; e.lv = lv; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    e = sb.pop_front();
    cmp({e.tag, ".time"},  32'(time_bin),  e.t);
    cmp({e.tag, ".bcd"},   32'(bcd_time),  32'(exp_bcd(e.t)));
    cmp({e.tag, ".state"}, 32'(state),     e.st);
    cmp({e.tag, ".lives"}, 32'(lives),     e.lv);
    cmp({e.tag, ".run"},   32'(running),   32'(e.st == 1));
    cmp({e.tag, ".warn"},  32'(warn),      32'(e.st == 1 && e.t <= 10));
    cmp({e.tag, ".over"},  32'(game_over), 32'(e.st == 4));
    cmp({e.tag, ".win"},   32'(win),       32'(e.st == 5));
  endtask

  task automatic step(input logic tk, input logic bh, input logic bl,
                      input int t, input int st, input int lv, input string tag);
    tick = tk; brick_hit = bh; ball_lost = bl;
    push(t, st, lv, tag);
    @(posedge tclk);
    #1;
    tick = 1'b0; brick_hit = 1'b0; ball_lost = 1'b0;
    check_now();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; diff = 1'b0;
    tick = 1'b0; brick_hit = 1'b0; ball_lost = 1'b0; level_clr = 1'b0;
    #2;
    push(300, 0, 3, "reset");
    check_now();
    #10 reset = 1'b0;
    @(posedge tclk);
    #1;

    step(0, 0, 0, 300, 0, 3, "idle");
    start = 1'b1;
    step(0, 0, 0, 300, 1, 3, "start");
    for (int k = 1; k <= 200; k++) step(1, 0, 0, 300 - k, 1, 3, "countdown");
    step(1, 0, 0, 99, 1, 3, "bcd_borrow");
    step(1, 1, 0, 103, 1, 3, "tick_bonus");
    for (int k = 1; k <= 179; k++) step(0, 1, 0, 103 + 5 * k, 1, 3, "bonus");
    step(1, 0, 0, 997, 1, 3, "to997");
    step(0, 1, 0, 999, 1, 3, "saturate");

    pause = 1'b1;
    step(0, 0, 0, 999, 2, 3, "pause");
    for (int k = 0; k < 5; k++) step(1, 0, 0, 999, 2, 3, "pause_tick");
    step(0, 1, 1, 999, 2, 3, "pause_ignore");
    pause = 1'b0;
    step(0, 0, 0, 999, 1, 3, "resume");

    step(0, 0, 1, 999, 3, 2, "lost1");
    step(0, 1, 0, 999, 3, 2, "lost_brick");
    step(1, 0, 0, 999, 3, 2, "respawn1a");
    step(1, 0, 0, 999, 1, 2, "respawn1b");
    step(0, 0, 1, 999, 3, 1, "lost2");
    step(1, 0, 0, 999, 3, 1, "respawn2a");
    step(1, 0, 0, 999, 1, 1, "respawn2b");
    step(0, 0, 1, 999, 4, 0, "lost3");
    step(1, 1, 0, 999, 4, 0, "over_hold");

    diff = 1'b1; start = 1'b0;
    step(0, 0, 0, 180, 0, 3, "idle_hard");
    start = 1'b1;
    step(0, 0, 0, 180, 1, 3, "start_hard");
    for (int k = 1; k <= 179; k++) step(1, 0, 0, 180 - k, 1, 3, "hard_count");
    step(1, 0, 0, 0, 4, 3, "time_out");
    step(1, 0, 0, 0, 4, 3, "zero_hold");
    start = 1'b0;
    step(0, 0, 0, 180, 0, 3, "reload_hard");

    diff = 1'b0; start = 1'b1;
    step(0, 0, 0, 300, 1, 3, "start_easy");
    level_clr = 1'b1;
    step(0, 0, 1, 300, 5, 3, "won");
    step(1, 0, 0, 300, 5, 3, "won_hold");
    level_clr = 1'b0;
    step(0, 0, 0, 300, 5, 3, "won_hold2");
    start = 1'b0;
    step(0, 0, 0, 300, 0, 3, "won_idle");
    start = 1'b1;
    step(0, 0, 0, 300, 1, 3, "rerun");
    step(1, 0, 0, 299, 1, 3, "rerun_tick");

    #3 reset = 1'b1;
    #1;
    push(300, 0, 3, "async_reset");
    check_now();
    start = 1'b0;
    #2 reset = 1'b0;
    @(posedge tclk);
    #1;
    step(0, 0, 0, 300, 0, 3, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
